ir_sense_seq: RTL and testbench

Upstream feeder for the IR heading-fusion math. Per sample period it enables the IR emitters, waits for optics to settle, and converts the left then right IR channels on the shared A2D through a start/complete handshake. It then derives open-wall flags with hysteresis and a saturated derivative term. Its outputs drive lft_IR, rght_IR, lft_opn, rght_opn and IR_Dtrm of the fusion stage.

---
 rtl/ir_sense_if.sv | 25 ++
 rtl/ir_sense_seq.sv | 194 +++++++++++++++++++
 tb/tb_ir_sense_seq.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_sense_if.sv
// A2D start/complete handshake plus the published IR sample set for the fusion stage.
// master = sequencer side, slave = A2D model / fusion consumer side.
interface ir_sense_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        IR_en;
    logic [11:0] lft_IR;
    logic [11:0] rght_IR;
    logic        lft_opn;
    logic        rght_opn;
    logic [8:0]  IR_Dtrm;
    logic        IR_vld;

    modport master (
        output strt_cnv, chnnl, IR_en, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, IR_vld,
        input  cnv_cmplt, res
    );

    modport slave (
        input  strt_cnv, chnnl, IR_en, lft_IR, rght_IR, lft_opn, rght_opn, IR_Dtrm, IR_vld,
        output cnv_cmplt, res
    );
endinterface

// File: rtl/ir_sense_seq.sv
// IR sample sequencer: emitter settle, left/right A2D conversions, open flags with hysteresis, saturated derivative.
// Latency: IR_vld 2 clocks after the right cnv_cmplt; define IR_AVG_EN to average each channel with its previous raw.
// Backpressure: none; periodic ticks arriving mid-sequence are dropped, A2D requests never overlap.
module ir_sense_seq #(
    parameter int          SMPL_PRD  = 4096,
    parameter int          SETTLE    = 256,
    parameter logic [2:0]  LFT_CHNL  = 3'd1,
    parameter logic [2:0]  RGHT_CHNL = 3'd4,
    parameter logic [11:0] OPN_THRES = 12'h300,
    parameter logic [11:0] HYST      = 12'h080,
    parameter logic [3:0]  D_GAIN    = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    ir_sense_if.master ir
);

    localparam int CW = $clog2(SMPL_PRD);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [12:0] OPEN_LVL = {1'b0, OPN_THRES};
    localparam logic [12:0] CLR_LVL  = {1'b0, OPN_THRES} + {1'b0, HYST};

    typedef enum logic [2:0] {IDLE, SETL, WAIT_L, WAIT_R, CALC} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic [SW-1:0]      scnt;
    logic               abrt;
    logic [11:0]        l_raw, r_raw;
    logic signed [12:0] prev_diff;
    logic               prev_valid;

    logic [11:0]        l_val, r_val;
    logic               l_opn_n, r_opn_n;
    logic signed [12:0] diff;
    logic signed [13:0] delta;
    logic signed [17:0] prod;
    logic [8:0]         sat;
    logic [8:0]         dtrm_n;

`ifdef IR_AVG_EN
    logic [11:0]        l_prev, r_prev;
    logic               avg_ok;
`endif

    assign tick = en && (cnt == CW'(SMPL_PRD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_comb begin
`ifdef IR_AVG_EN
        l_val = avg_ok ? 12'(({1'b0, l_raw} + {1'b0, l_prev}) >> 1) : l_raw;
        r_val = avg_ok ? 12'(({1'b0, r_raw} + {1'b0, r_prev}) >> 1) : r_raw;
`else
        l_val = l_raw;
        r_val = r_raw;
`endif
        // Readings inside the hysteresis band keep the previous flag
        l_opn_n = ir.lft_opn;
        if ({1'b0, l_val} < OPEN_LVL)
            l_opn_n = 1'b1;
        else if ({1'b0, l_val} > CLR_LVL)
            l_opn_n = 1'b0;
        r_opn_n = ir.rght_opn;
        if ({1'b0, r_val} < OPEN_LVL)
            r_opn_n = 1'b1;
        else if ({1'b0, r_val} > CLR_LVL)
            r_opn_n = 1'b0;

        diff  = $signed({1'b0, l_val}) - $signed({1'b0, r_val});
        delta = $signed({diff[12], diff}) - $signed({prev_diff[12], prev_diff});
        prod  = $signed({{4{delta[13]}}, delta}) * $signed({14'd0, D_GAIN});
        if (prod > 18'sd255)
            sat = 9'h0FF;
        else if (prod < -18'sd256)
            sat = 9'h100;
        else
            sat = prod[8:0];
        dtrm_n = (!l_opn_n && !r_opn_n && prev_valid) ? sat : 9'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            scnt        <= '0;
            abrt        <= 1'b0;
            l_raw       <= '0;
            r_raw       <= '0;
            prev_diff   <= '0;
            prev_valid  <= 1'b0;
            ir.IR_en    <= 1'b0;
            ir.strt_cnv <= 1'b0;
            ir.chnnl    <= LFT_CHNL;
            ir.lft_IR   <= '0;
            ir.rght_IR  <= '0;
            ir.lft_opn  <= 1'b1;
            ir.rght_opn <= 1'b1;
            ir.IR_Dtrm  <= '0;
            ir.IR_vld   <= 1'b0;
`ifdef IR_AVG_EN
            l_prev      <= '0;
            r_prev      <= '0;
            avg_ok      <= 1'b0;
`endif
        end else begin
            ir.strt_cnv <= 1'b0;
            ir.IR_vld   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        ir.IR_en <= 1'b1;
                        scnt     <= '0;
                        state    <= SETL;
                    end
                end
                SETL: begin
                    if (!en) begin
                        ir.IR_en <= 1'b0;
                        state    <= IDLE;
                    end else if (scnt == SW'(SETTLE - 1)) begin
                        ir.strt_cnv <= 1'b1;
                        ir.chnnl    <= LFT_CHNL;
                        state       <= WAIT_L;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                // An aborted conversion is still waited out so the A2D is never left mid-request
                WAIT_L: begin
                    if (!en)
                        abrt <= 1'b1;
                    if (ir.cnv_cmplt) begin
                        if (abrt || !en) begin
                            abrt     <= 1'b0;
                            ir.IR_en <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            l_raw       <= ir.res;
                            ir.strt_cnv <= 1'b1;
                            ir.chnnl    <= RGHT_CHNL;
                            state       <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (!en)
                        abrt <= 1'b1;
                    if (ir.cnv_cmplt) begin
                        ir.IR_en <= 1'b0;
                        ir.chnnl <= LFT_CHNL;
                        if (abrt || !en) begin
                            abrt  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            r_raw <= ir.res;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    ir.lft_IR   <= l_val;
                    ir.rght_IR  <= r_val;
                    ir.lft_opn  <= l_opn_n;
                    ir.rght_opn <= r_opn_n;
                    ir.IR_Dtrm  <= dtrm_n;
                    ir.IR_vld   <= 1'b1;
                    prev_diff   <= diff;
                    prev_valid  <= !l_opn_n && !r_opn_n;
`ifdef IR_AVG_EN
                    l_prev      <= l_raw;
                    r_prev      <= r_raw;
                    avg_ok      <= 1'b1;
`endif
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef IR_AVG_EN
            if (!en)
                avg_ok <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ir_sense_seq.sv
// Directed bench for ir_sense_seq with a behavioural A2D (per-channel latency) and protocol monitors.
module tb_ir_sense_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #5 clk = ~clk;

    ir_sense_if ifc();

    ir_sense_seq #(.SMPL_PRD(64), .SETTLE(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .ir   (ifc)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] l_val = 12'h000;
    logic [11:0] r_val = 12'h000;
    int l_dly = 20;
    int r_dly = 20;
    int n_strt_l = 0, n_strt_r = 0, overlap_err = 0, chnl_err = 0;

`ifdef IR_AVG_EN
    localparam logic [11:0] EXP_AVG2 = 12'h880;
`else
    localparam logic [11:0] EXP_AVG2 = 12'h900;
`endif

    // A2D model: accepts strt_cnv, answers after the channel's latency with a one-clock cnv_cmplt
    initial begin
        automatic int cnt = 0;
        automatic bit busy = 0;
        automatic logic [2:0] cur = 3'd0;
        ifc.cnv_cmplt = 1'b0;
        ifc.res = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            ifc.cnv_cmplt = 1'b0;
            if (busy) begin
                if (ifc.strt_cnv === 1'b1) overlap_err++;
                if (ifc.chnnl !== cur) chnl_err++;
                cnt--;
                if (cnt == 0) begin
                    ifc.cnv_cmplt = 1'b1;
                    ifc.res = (cur == 3'd1) ? l_val : r_val;
                    busy = 0;
                end
            end else if (ifc.strt_cnv === 1'b1) begin
                busy = 1;
                cur = ifc.chnnl;
                cnt = (cur == 3'd1) ? l_dly : r_dly;
                if (cur == 3'd1) n_strt_l++; else n_strt_r++;
            end
        end
    end

    task automatic wait_vld(input int lim, output bit got);
        got = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ifc.IR_vld === 1'b1) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic run_sample(input logic [11:0] lv, input logic [11:0] rv, input bit toggle, output bit got);
        l_val = lv;
        r_val = rv;
        if (toggle) begin
            @(negedge clk); en = 1'b0;
            @(negedge clk); en = 1'b1;
        end
        wait_vld(300, got);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ifc.IR_en, ifc.strt_cnv, ifc.chnnl, ifc.lft_opn, ifc.rght_opn, ifc.IR_vld} !== 8'b0_0_001_1_1_0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=%b", {ifc.IR_en, ifc.strt_cnv, ifc.chnnl, ifc.lft_opn, ifc.rght_opn, ifc.IR_vld}, 8'b0_0_001_1_1_0);
        end
        checks++;
        if ({ifc.lft_IR, ifc.rght_IR, ifc.IR_Dtrm} !== 33'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {ifc.lft_IR, ifc.rght_IR, ifc.IR_Dtrm});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_sample();
        int c0, t_en, t_s1, t_s2, t_c2, t_vld, ns, nc;
        logic [2:0] ch1, ch2;
        logic en_at_c2;
        t_en = -1; t_s1 = -1; t_s2 = -1; t_c2 = -1; t_vld = -1; ns = 0; nc = 0;
        ch1 = 3'd0; ch2 = 3'd0; en_at_c2 = 1'b0;
        l_val = 12'h900; r_val = 12'h900;
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifc.IR_en === 1'b1 && t_en < 0) t_en = cyc;
            if (ifc.strt_cnv === 1'b1) begin
                if (ns == 0) begin t_s1 = cyc; ch1 = ifc.chnnl; end
                else begin t_s2 = cyc; ch2 = ifc.chnnl; end
                ns++;
            end
            if (ifc.cnv_cmplt === 1'b1) begin
                nc++;
                if (nc == 2) begin t_c2 = cyc; en_at_c2 = ifc.IR_en; end
            end
            if (ifc.IR_vld === 1'b1) begin t_vld = cyc; break; end
        end
        checks++;
        if (t_vld < 0) begin failures++; $display("FAIL first_timeout got=no IR_vld exp=IR_vld"); end
        checks++;
        if (t_en - c0 !== 64) begin failures++; $display("FAIL ir_en_at_wrap got=%0d exp=64", t_en - c0); end
        checks++;
        if (t_s1 - t_en !== 8) begin failures++; $display("FAIL settle_len got=%0d exp=8", t_s1 - t_en); end
        checks++;
        if (ch1 !== 3'd1 || ch2 !== 3'd4) begin failures++; $display("FAIL chnl_order got=%0d,%0d exp=1,4", ch1, ch2); end
        checks++;
        if (t_s2 - t_s1 !== 21) begin failures++; $display("FAIL strt_spacing got=%0d exp=21", t_s2 - t_s1); end
        checks++;
        if (en_at_c2 !== 1'b1) begin failures++; $display("FAIL ir_en_at_cmplt got=%b exp=1", en_at_c2); end
        checks++;
        if (t_vld - t_c2 !== 2) begin failures++; $display("FAIL vld_latency got=%0d exp=2", t_vld - t_c2); end
        checks++;
        if ({ifc.IR_en, ifc.lft_IR, ifc.rght_IR, ifc.lft_opn, ifc.rght_opn, ifc.IR_Dtrm} !== {1'b0, 12'h900, 12'h900, 2'b00, 9'h000}) begin
            failures++;
            $display("FAIL first_outputs got=%h exp=%h", {ifc.IR_en, ifc.lft_IR, ifc.rght_IR, ifc.lft_opn, ifc.rght_opn, ifc.IR_Dtrm}, {1'b0, 12'h900, 12'h900, 2'b00, 9'h000});
        end
        @(negedge clk);
        checks++;
        if (ifc.IR_vld !== 1'b0) begin failures++; $display("FAIL vld_pulse got=%b exp=0", ifc.IR_vld); end
    endtask

    task automatic test_derivative();
        logic [11:0] lv [5] = '{12'h940, 12'hA00, 12'h400, 12'h900, 12'h900};
        logic [11:0] rv [5] = '{12'h900, 12'h900, 12'hF00, 12'h930, 12'h940};
        logic [8:0]  ed [5] = '{9'h080, 9'h0FF, 9'h100, 9'h0FF, 9'h1E0};
        bit got;
        for (int i = 0; i < 5; i++) begin
            run_sample(lv[i], rv[i], 1'b1, got);
            checks++;
            if (!got || ifc.IR_Dtrm !== ed[i] || ifc.lft_IR !== lv[i]) begin
                failures++;
                $display("FAIL dtrm_%0d got=%h/%h vld=%b exp=%h/%h", i, ifc.IR_Dtrm, ifc.lft_IR, got, ed[i], lv[i]);
            end
        end
    endtask

    task automatic test_hysteresis();
        logic [11:0] lv [7] = '{12'h2F0, 12'h350, 12'h390, 12'h380, 12'h2FF, 12'h381, 12'h900};
        logic [11:0] rv [7] = '{12'h900, 12'h900, 12'h900, 12'h900, 12'h900, 12'h900, 12'h100};
        logic [1:0]  eo [7] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [8:0]  ed [7] = '{9'h000, 9'h000, 9'h000, 9'h1E0, 9'h000, 9'h000, 9'h000};
        bit got;
        for (int i = 0; i < 7; i++) begin
            run_sample(lv[i], rv[i], 1'b1, got);
            checks++;
            if (!got || {ifc.lft_opn, ifc.rght_opn} !== eo[i] || ifc.IR_Dtrm !== ed[i]) begin
                failures++;
                $display("FAIL hyst_%0d got=opn%b dtrm=%h vld=%b exp=opn%b dtrm=%h", i, {ifc.lft_opn, ifc.rght_opn}, ifc.IR_Dtrm, got, eo[i], ed[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        bit seen_r, c_seen, vld_seen, en_at_c, en_after, got;
        int c0, t_en;
        seen_r = 0; c_seen = 0; vld_seen = 0; en_at_c = 0; en_after = 1; t_en = -1;
        l_val = 12'h111; r_val = 12'h222;
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifc.strt_cnv === 1'b1 && ifc.chnnl === 3'd4) begin seen_r = 1; en = 1'b0; break; end
        end
        checks++;
        if (!seen_r) begin failures++; $display("FAIL drop_no_right_strt got=none exp=strt chnl4"); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.IR_vld === 1'b1) vld_seen = 1;
            if (c_seen) begin en_after = ifc.IR_en; c_seen = 0; en_at_c = en_at_c | 1'b0; break; end
            if (ifc.cnv_cmplt === 1'b1) begin c_seen = 1; en_at_c = ifc.IR_en; end
        end
        checks++;
        if (en_at_c !== 1'b1 || en_after !== 1'b0) begin
            failures++;
            $display("FAIL drop_ir_en got=%b%b exp=10", en_at_c, en_after);
        end
        repeat (20) begin
            @(negedge clk);
            if (ifc.IR_vld === 1'b1) vld_seen = 1;
        end
        checks++;
        if (vld_seen) begin failures++; $display("FAIL drop_vld got=1 exp=0"); end
        checks++;
        if ({ifc.lft_IR, ifc.rght_IR, ifc.lft_opn, ifc.rght_opn, ifc.IR_Dtrm} !== {12'h900, 12'h100, 2'b01, 9'h000}) begin
            failures++;
            $display("FAIL drop_hold got=%h exp=%h", {ifc.lft_IR, ifc.rght_IR, ifc.lft_opn, ifc.rght_opn, ifc.IR_Dtrm}, {12'h900, 12'h100, 2'b01, 9'h000});
        end
        @(negedge clk);
        c0 = cyc;
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc.IR_en === 1'b1) begin t_en = cyc; break; end
        end
        checks++;
        if (t_en - c0 !== 64) begin failures++; $display("FAIL drop_counter_held got=%0d exp=64", t_en - c0); end
        wait_vld(200, got);
        checks++;
        if (!got || {ifc.lft_IR, ifc.rght_IR, ifc.lft_opn, ifc.rght_opn} !== {12'h111, 12'h222, 2'b11}) begin
            failures++;
            $display("FAIL drop_resume got=%h vld=%b exp=%h", {ifc.lft_IR, ifc.rght_IR, ifc.lft_opn, ifc.rght_opn}, got, {12'h111, 12'h222, 2'b11});
        end
    endtask

    task automatic test_stretch();
        int t_e1, t_e2, nl, nr;
        bit prev_en, got_vld, got;
        t_e1 = -1; t_e2 = -1; nl = 0; nr = 0; prev_en = 0; got_vld = 0;
        l_val = 12'h900; r_val = 12'h900;
        l_dly = 100;
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        n_strt_l = 0; n_strt_r = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifc.IR_en === 1'b1 && !prev_en) begin
                if (t_e1 < 0) t_e1 = cyc;
                else begin t_e2 = cyc; l_dly = 20; break; end
            end
            prev_en = (ifc.IR_en === 1'b1);
            if (ifc.IR_vld === 1'b1 && !got_vld) begin got_vld = 1; nl = n_strt_l; nr = n_strt_r; end
        end
        l_dly = 20;
        checks++;
        if (!got_vld || nl !== 1 || nr !== 1) begin
            failures++;
            $display("FAIL stretch_strt_count got=%0d/%0d vld=%b exp=1/1", nl, nr, got_vld);
        end
        checks++;
        if (t_e2 - t_e1 !== 192) begin failures++; $display("FAIL stretch_tick_dropped got=%0d exp=192", t_e2 - t_e1); end
        wait_vld(200, got);
        checks++;
        if (!got) begin failures++; $display("FAIL stretch_next_seq got=no IR_vld exp=IR_vld"); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        l_val = 12'h900; r_val = 12'h900;
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifc.strt_cnv === 1'b1) begin seen = 1; break; end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || {ifc.IR_en, ifc.strt_cnv, ifc.chnnl, ifc.lft_opn, ifc.rght_opn, ifc.IR_vld} !== 8'b0_0_001_1_1_0) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b strt=%b exp=%b", {ifc.IR_en, ifc.strt_cnv, ifc.chnnl, ifc.lft_opn, ifc.rght_opn, ifc.IR_vld}, seen, 8'b0_0_001_1_1_0);
        end
        checks++;
        if ({ifc.lft_IR, ifc.rght_IR, ifc.IR_Dtrm} !== 33'd0) begin
            failures++;
            $display("FAIL rstmid_data got=%h exp=0", {ifc.lft_IR, ifc.rght_IR, ifc.IR_Dtrm});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_avg();
        bit got;
        run_sample(12'h800, 12'h900, 1'b0, got);
        checks++;
        if (!got || ifc.lft_IR !== 12'h800) begin failures++; $display("FAIL avg_first got=%h vld=%b exp=800", ifc.lft_IR, got); end
        run_sample(12'h900, 12'h900, 1'b0, got);
        checks++;
        if (!got || ifc.lft_IR !== EXP_AVG2 || ifc.rght_IR !== 12'h900) begin
            failures++;
            $display("FAIL avg_second got=%h/%h vld=%b exp=%h/900", ifc.lft_IR, ifc.rght_IR, got, EXP_AVG2);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (overlap_err !== 0 || chnl_err !== 0) begin
            failures++;
            $display("FAIL a2d_protocol got=overlap%0d chnl%0d exp=0/0", overlap_err, chnl_err);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_derivative();
        test_hysteresis();
        test_en_drop();
        test_stretch();
        test_reset_mid();
        test_avg();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
